llr_replay_engine: RTL and testbench

Parametrised link-layer retry block: retry buffer plus replay engine (remote-request side) plus local retry state machine (LRSM) with timeout and threshold escalation. Sits between the flit packer/CRC generator (write side) and MUX-2 (replay side), with control from the unpacker and register file. Successor to the fixed 528-bit / 256-entry retry block: width, depth and counter widths are generic, and it adds implicit ack on retry request, replay restart and eseq range checking.

---
 rtl/llr_replay_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_llr_replay_engine.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_replay_engine.sv
// Link-layer retry buffer, replay engine and local retry state machine (LRSM).
// Define LLR_TIMEOUT_EN to enable the wait-state timeout with PHY re-init / abort escalation.
module llr_replay_engine #(
   parameter int FLIT_W = 528,
   parameter int DEPTH  = 256,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int ACK_W  = 8,
   parameter int THR_W  = 5,
   parameter int TMO_W  = 13
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [FLIT_W-1:0] i_wr_flit,
   output logic              o_wr_ready,
   output logic [PTR_W-1:0]  o_wrt_ptr,
   input  logic              i_ack_valid,
   input  logic [ACK_W-1:0]  i_ack_num,
   input  logic              i_retry_req,
   input  logic [PTR_W-1:0]  i_retry_eseq,
   output logic              o_retry_ack,
   output logic              o_eseq_err,
   output logic              o_rd_valid,
   output logic [FLIT_W-1:0] o_rd_flit,
   input  logic              i_rd_ready,
   input  logic              i_crc_err,
   output logic              o_send_retry_req,
   input  logic              i_ctrl_sent,
   input  logic              i_remote_retry_ack,
   output logic              o_discard,
   input  logic [THR_W-1:0]  i_retry_threshold,
   input  logic [THR_W-1:0]  i_reinit_threshold,
   input  logic [TMO_W-1:0]  i_timeout_max,
   output logic              o_phy_reinit_req,
   input  logic              i_phy_link_up,
   output logic              o_link_failure,
   output logic [2:0]        o_lrsm_state,
   output logic [PTR_W:0]    o_buf_consumed
);

   localparam int CNT_W = PTR_W + 1;
   localparam int CMP_W = (ACK_W > CNT_W) ? ACK_W : CNT_W;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [2:0] {
      ST_NORMAL     = 3'd0,
      ST_RETRY_REQ  = 3'd1,
      ST_RETRY_WAIT = 3'd2,
      ST_PHY_REINIT = 3'd3,
      ST_ABORT      = 3'd4
   } lrsm_state_t;

   logic [FLIT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_rp_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_rp_left;
   logic              r_ready_en;
   logic              r_replay_pend;
   logic              r_replay_active;
   logic              r_retry_ack;
   logic              r_eseq_err;

   logic              w_busy;
   logic              w_wr_ready;
   logic              w_wr_acc;
   logic [PTR_W-1:0]  w_d_raw;
   logic [CNT_W-1:0]  w_d;
   logic [CNT_W-1:0]  w_ack_freed;
   logic [CNT_W-1:0]  w_freed;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_retry_ok;
   logic              w_retry_bad;

   // Writes are blocked from the retry request until the last replayed flit is taken.
   assign w_busy      = r_replay_pend | r_replay_active;
   assign w_wr_ready  = r_ready_en && (r_count < FULL) && !w_busy;
   assign w_wr_acc    = i_wr_en && w_wr_ready;

   // A full buffer with eseq equal to the write pointer means every entry is replayed.
   assign w_d_raw     = r_wr_ptr - i_retry_eseq;
   assign w_d         = (r_count == FULL && w_d_raw == '0) ? FULL : {1'b0, w_d_raw};
   assign w_retry_ok  = i_retry_req && (w_d <= r_count);
   assign w_retry_bad = i_retry_req && !w_retry_ok;
   assign w_ack_freed = (CMP_W'(i_ack_num) < CMP_W'(r_count)) ? CNT_W'(i_ack_num) : r_count;

   always_comb begin
      w_freed = '0;
      if (w_retry_ok) begin
         w_freed = r_count - w_d;
      end else if (i_ack_valid) begin
         w_freed = w_ack_freed;
      end
   end

   assign w_count_nxt = r_count - w_freed + CNT_W'(w_wr_acc);

   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= i_wr_flit;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ready_en      <= 1'b0;
         r_wr_ptr        <= '0;
         r_rd_ptr        <= '0;
         r_rp_ptr        <= '0;
         r_count         <= '0;
         r_rp_left       <= '0;
         r_replay_pend   <= 1'b0;
         r_replay_active <= 1'b0;
         r_retry_ack     <= 1'b0;
         r_eseq_err      <= 1'b0;
      end else begin
         r_ready_en  <= 1'b1;
         r_count     <= w_count_nxt;
         r_retry_ack <= w_retry_ok;
         r_eseq_err  <= w_retry_bad;
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_retry_ok) begin
            r_rd_ptr <= i_retry_eseq;
         end else begin
            r_rd_ptr <= r_rd_ptr + w_freed[PTR_W-1:0];
         end
         // One idle cycle after a (re)start so the first flit appears two cycles after the request.
         if (w_retry_ok) begin
            r_rp_ptr        <= i_retry_eseq;
            r_rp_left       <= w_d;
            r_replay_pend   <= (w_d != '0);
            r_replay_active <= 1'b0;
         end else begin
            r_replay_pend <= 1'b0;
            if (r_replay_pend) begin
               r_replay_active <= 1'b1;
            end else if (r_replay_active && i_rd_ready) begin
               r_rp_ptr  <= r_rp_ptr + PTR_W'(1);
               r_rp_left <= r_rp_left - CNT_W'(1);
               if (r_rp_left == CNT_W'(1)) begin
                  r_replay_active <= 1'b0;
               end
            end
         end
      end
   end

   assign o_wr_ready     = w_wr_ready;
   assign o_wrt_ptr      = r_wr_ptr;
   assign o_buf_consumed = r_count;
   assign o_retry_ack    = r_retry_ack;
   assign o_eseq_err     = r_eseq_err;
   assign o_rd_valid     = r_replay_active;
   assign o_rd_flit      = r_replay_active ? r_mem[r_rp_ptr] : '0;

   lrsm_state_t r_state;
   lrsm_state_t w_state_nxt;

`ifdef LLR_TIMEOUT_EN
   logic [TMO_W-1:0] r_tmo;
   logic [THR_W-1:0] r_retry_cnt;
   logic [THR_W-1:0] r_reinit_cnt;
   logic [THR_W-1:0] w_retry_cnt_nxt;
   logic [THR_W-1:0] w_reinit_cnt_nxt;
   logic [THR_W:0]   w_retry_inc;
   logic [THR_W:0]   w_reinit_inc;
   logic             w_timeout;
   logic             r_link_failure;

   // Increments are one bit wider so a counter at its maximum cannot wrap below the threshold.
   assign w_retry_inc  = {1'b0, r_retry_cnt} + (THR_W+1)'(1);
   assign w_reinit_inc = {1'b0, r_reinit_cnt} + (THR_W+1)'(1);
   assign w_timeout    = (r_state == ST_RETRY_WAIT) && (r_tmo == i_timeout_max);
`endif

   always_comb begin
      w_state_nxt = r_state;
`ifdef LLR_TIMEOUT_EN
      w_retry_cnt_nxt  = r_retry_cnt;
      w_reinit_cnt_nxt = r_reinit_cnt;
`endif
      case (r_state)
         ST_NORMAL: begin
            if (i_crc_err) begin
               w_state_nxt = ST_RETRY_REQ;
            end
         end
         ST_RETRY_REQ: begin
            if (i_ctrl_sent) begin
               w_state_nxt = ST_RETRY_WAIT;
            end
         end
         ST_RETRY_WAIT: begin
            if (i_remote_retry_ack) begin
               w_state_nxt = ST_NORMAL;
`ifdef LLR_TIMEOUT_EN
               w_retry_cnt_nxt  = '0;
               w_reinit_cnt_nxt = '0;
            end else if (w_timeout) begin
               if (w_retry_inc >= {1'b0, i_retry_threshold}) begin
                  w_retry_cnt_nxt  = '0;
                  w_reinit_cnt_nxt = w_reinit_inc[THR_W-1:0];
                  w_state_nxt = (w_reinit_inc >= {1'b0, i_reinit_threshold}) ? ST_ABORT : ST_PHY_REINIT;
               end else begin
                  w_retry_cnt_nxt = w_retry_inc[THR_W-1:0];
                  w_state_nxt     = ST_RETRY_REQ;
               end
`endif
            end
         end
         ST_PHY_REINIT: begin
            if (i_phy_link_up) begin
               w_state_nxt = ST_RETRY_REQ;
            end
         end
         ST_ABORT: begin
            w_state_nxt = ST_ABORT;
         end
         default: begin
            w_state_nxt = ST_NORMAL;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_NORMAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

`ifdef LLR_TIMEOUT_EN
   // Timeout counter restarts from zero on every entry into RETRY_WAIT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tmo          <= '0;
         r_retry_cnt    <= '0;
         r_reinit_cnt   <= '0;
         r_link_failure <= 1'b0;
      end else begin
         r_retry_cnt  <= w_retry_cnt_nxt;
         r_reinit_cnt <= w_reinit_cnt_nxt;
         if (r_state == ST_RETRY_WAIT && w_state_nxt == ST_RETRY_WAIT) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end else begin
            r_tmo <= '0;
         end
         if (w_state_nxt == ST_ABORT) begin
            r_link_failure <= 1'b1;
         end
      end
   end

   assign o_phy_reinit_req = (r_state == ST_PHY_REINIT);
   assign o_link_failure   = r_link_failure;
`else
   logic w_unused_cfg;
   assign w_unused_cfg     = ^{i_timeout_max, i_retry_threshold, i_reinit_threshold};
   assign o_phy_reinit_req = 1'b0;
   assign o_link_failure   = 1'b0;
`endif

   assign o_send_retry_req = (r_state == ST_RETRY_REQ);
   assign o_discard        = (r_state != ST_NORMAL);
   assign o_lrsm_state     = r_state;

endmodule

// File: tb/tb_llr_replay_engine.sv
// Self-checking bench for llr_replay_engine (DEPTH=8, 32-bit flits) with a replay scoreboard.
// Escalation checks build when LLR_TIMEOUT_EN is defined, the no-timeout check otherwise.
module tb_llr_replay_engine;

   localparam int FW = 32;
   localparam int DP = 8;
   localparam int PW = 3;

   logic          clock;
   logic          reset;
   logic          wrEn;
   logic [FW-1:0] wrFlit;
   logic          wrReady;
   logic [PW-1:0] wrtPtr;
   logic          ackValid;
   logic [7:0]    ackNum;
   logic          retryReq;
   logic [PW-1:0] retryEseq;
   logic          retryAck;
   logic          eseqErr;
   logic          rdValid;
   logic [FW-1:0] rdFlit;
   logic          rdReady;
   logic          crcErr;
   logic          sendRetryReq;
   logic          ctrlSent;
   logic          remoteRetryAck;
   logic          discard;
   logic [4:0]    retryThreshold;
   logic [4:0]    reinitThreshold;
   logic [12:0]   timeoutMax;
   logic          phyReinitReq;
   logic          phyLinkUp;
   logic          linkFailure;
   logic [2:0]    lrsmState;
   logic [PW:0]   bufConsumed;

   int vecCount = 0;
   int failCount = 0;
   int tagCounter = 0;
   int mdlWr = 0;
   logic [FW-1:0] mdlMem [DP];
   logic [FW-1:0] expQ [$];

   llr_replay_engine #(
      .FLIT_W(FW), .DEPTH(DP), .PTR_W(PW), .ACK_W(8), .THR_W(5), .TMO_W(13)
   ) dut (
      .i_clk(clock), .i_rst(reset),
      .i_wr_en(wrEn), .i_wr_flit(wrFlit), .o_wr_ready(wrReady), .o_wrt_ptr(wrtPtr),
      .i_ack_valid(ackValid), .i_ack_num(ackNum),
      .i_retry_req(retryReq), .i_retry_eseq(retryEseq),
      .o_retry_ack(retryAck), .o_eseq_err(eseqErr),
      .o_rd_valid(rdValid), .o_rd_flit(rdFlit), .i_rd_ready(rdReady),
      .i_crc_err(crcErr), .o_send_retry_req(sendRetryReq), .i_ctrl_sent(ctrlSent),
      .i_remote_retry_ack(remoteRetryAck), .o_discard(discard),
      .i_retry_threshold(retryThreshold), .i_reinit_threshold(reinitThreshold),
      .i_timeout_max(timeoutMax), .o_phy_reinit_req(phyReinitReq),
      .i_phy_link_up(phyLinkUp), .o_link_failure(linkFailure),
      .o_lrsm_state(lrsmState), .o_buf_consumed(bufConsumed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change and outputs are sampled 1ns after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      mdlWr = 0;
      expQ.delete();
   endtask

   task automatic writeFlits(input int n);
      logic [FW-1:0] data;
      for (int i = 0; i < n; i++) begin
         data = 32'hA500_0000 | FW'(tagCounter);
         tagCounter++;
         wrEn = 1'b1;
         wrFlit = data;
         mdlMem[mdlWr] = data;
         mdlWr = (mdlWr + 1) % DP;
         tick();
      end
      wrEn = 1'b0;
   endtask

   task automatic applyAck(input int n);
      ackValid = 1'b1;
      ackNum = 8'(n);
      tick();
      ackValid = 1'b0;
      ackNum = 8'd0;
   endtask

   task automatic pushReplay(input int eseq, input int d);
      for (int i = 0; i < d; i++) begin
         expQ.push_back(mdlMem[(eseq + i) % DP]);
      end
   endtask

   task automatic drainReplay(input string tag, input int budget);
      int cyc = 0;
      while ((rdValid || expQ.size() != 0) && cyc < budget) begin
         if (rdValid) begin
            vecCount++;
            if (expQ.size() == 0) begin
               failCount++;
               $display("[TB] FAIL %s_extra: got flit %0h, expected no flit", tag, rdFlit);
            end else begin
               if (rdFlit !== expQ[0]) begin
                  failCount++;
                  $display("[TB] FAIL %s_flit: got %0h, expected %0h", tag, rdFlit, expQ[0]);
               end
               void'(expQ.pop_front());
            end
         end
         tick();
         cyc++;
      end
      vecCount++;
      if (cyc >= budget) begin
         failCount++;
         $display("[TB] FAIL %s_timeout: %0d flits outstanding, expected 0", tag, expQ.size());
         expQ.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      vecCount++; if (wrReady !== 1'b0) begin failCount++; $display("[TB] FAIL rst_wr_ready: got %b expected 0", wrReady); end
      vecCount++; if (bufConsumed !== 4'd0) begin failCount++; $display("[TB] FAIL rst_consumed: got %0d expected 0", bufConsumed); end
      vecCount++; if (lrsmState !== 3'd0) begin failCount++; $display("[TB] FAIL rst_state: got %0d expected 0", lrsmState); end
      vecCount++; if ({rdValid, retryAck, eseqErr, discard, sendRetryReq, phyReinitReq, linkFailure} !== 7'd0) begin
         failCount++; $display("[TB] FAIL rst_flags: got %b expected 0000000", {rdValid, retryAck, eseqErr, discard, sendRetryReq, phyReinitReq, linkFailure});
      end
      vecCount++; if (wrtPtr !== 3'd0) begin failCount++; $display("[TB] FAIL rst_wrt_ptr: got %0d expected 0", wrtPtr); end
      reset = 1'b0;
      tick();
      vecCount++; if (wrReady !== 1'b1) begin failCount++; $display("[TB] FAIL rst_release_ready: got %b expected 1", wrReady); end
      mdlWr = 0;
   endtask

   task automatic test_fill_ack();
      applyReset();
      writeFlits(8);
      vecCount++; if (wrReady !== 1'b0) begin failCount++; $display("[TB] FAIL full_ready: got %b expected 0", wrReady); end
      vecCount++; if (bufConsumed !== 4'd8) begin failCount++; $display("[TB] FAIL full_consumed: got %0d expected 8", bufConsumed); end
      wrEn = 1'b1;
      wrFlit = 32'hDEAD_BEEF;
      tick();
      wrEn = 1'b0;
      vecCount++; if (wrtPtr !== 3'd0 || bufConsumed !== 4'd8) begin
         failCount++; $display("[TB] FAIL full_write_blocked: got ptr %0d cnt %0d expected ptr 0 cnt 8", wrtPtr, bufConsumed);
      end
      applyAck(3);
      vecCount++; if (bufConsumed !== 4'd5) begin failCount++; $display("[TB] FAIL ack3_consumed: got %0d expected 5", bufConsumed); end
      vecCount++; if (wrReady !== 1'b1) begin failCount++; $display("[TB] FAIL ack3_ready: got %b expected 1", wrReady); end
      applyAck(0);
      vecCount++; if (bufConsumed !== 4'd5) begin failCount++; $display("[TB] FAIL ack0_consumed: got %0d expected 5", bufConsumed); end
      applyAck(200);
      vecCount++; if (bufConsumed !== 4'd0) begin failCount++; $display("[TB] FAIL ack_over_consumed: got %0d expected 0", bufConsumed); end
   endtask

   task automatic test_retry_replay();
      applyReset();
      writeFlits(6);
      applyAck(2);
      retryReq = 1'b1;
      retryEseq = 3'd3;
      pushReplay(3, 3);
      tick();
      retryReq = 1'b0;
      rdReady = 1'b1;
      vecCount++; if (retryAck !== 1'b1) begin failCount++; $display("[TB] FAIL retry_ack: got %b expected 1", retryAck); end
      vecCount++; if (bufConsumed !== 4'd3) begin failCount++; $display("[TB] FAIL retry_consumed: got %0d expected 3", bufConsumed); end
      vecCount++; if (rdValid !== 1'b0) begin failCount++; $display("[TB] FAIL retry_valid_t1: got %b expected 0", rdValid); end
      tick();
      vecCount++; if (rdValid !== 1'b1) begin failCount++; $display("[TB] FAIL retry_valid_t2: got %b expected 1", rdValid); end
      vecCount++; if (retryAck !== 1'b0) begin failCount++; $display("[TB] FAIL retry_ack_pulse: got %b expected 0", retryAck); end
      drainReplay("replay", 20);
      vecCount++; if (bufConsumed !== 4'd3) begin failCount++; $display("[TB] FAIL replay_keeps_entries: got %0d expected 3", bufConsumed); end
      rdReady = 1'b0;
   endtask

   task automatic test_eseq_range();
      applyReset();
      writeFlits(8);
      retryReq = 1'b1;
      retryEseq = 3'd0;
      pushReplay(0, 8);
      tick();
      retryReq = 1'b0;
      rdReady = 1'b1;
      vecCount++; if (retryAck !== 1'b1 || bufConsumed !== 4'd8) begin
         failCount++; $display("[TB] FAIL full_retry: got ack %b cnt %0d expected ack 1 cnt 8", retryAck, bufConsumed);
      end
      drainReplay("full_replay", 30);
      rdReady = 1'b0;
      applyAck(4);
      retryReq = 1'b1;
      retryEseq = 3'd1;
      tick();
      retryReq = 1'b0;
      vecCount++; if (eseqErr !== 1'b1 || retryAck !== 1'b0) begin
         failCount++; $display("[TB] FAIL eseq_err: got err %b ack %b expected err 1 ack 0", eseqErr, retryAck);
      end
      tick();
      vecCount++; if (eseqErr !== 1'b0 || rdValid !== 1'b0 || bufConsumed !== 4'd4) begin
         failCount++; $display("[TB] FAIL eseq_err_after: got err %b valid %b cnt %0d expected 0 0 4", eseqErr, rdValid, bufConsumed);
      end
      retryReq = 1'b1;
      retryEseq = 3'd0;
      tick();
      retryReq = 1'b0;
      vecCount++; if (retryAck !== 1'b1 || bufConsumed !== 4'd0) begin
         failCount++; $display("[TB] FAIL retry_d0: got ack %b cnt %0d expected ack 1 cnt 0", retryAck, bufConsumed);
      end
      tick();
      tick();
      vecCount++; if (rdValid !== 1'b0) begin failCount++; $display("[TB] FAIL retry_d0_noreplay: got %b expected 0", rdValid); end
   endtask

   task automatic test_restart();
      int got = 0;
      int cyc = 0;
      applyReset();
      writeFlits(8);
      applyAck(2);
      retryReq = 1'b1;
      retryEseq = 3'd2;
      pushReplay(2, 6);
      tick();
      retryReq = 1'b0;
      rdReady = 1'b1;
      wrEn = 1'b1;
      wrFlit = 32'h5A5A_0001;
      while (got < 3 && cyc < 20) begin
         if (rdValid) begin
            vecCount++;
            if (rdFlit !== expQ[0]) begin
               failCount++; $display("[TB] FAIL restart_pre_flit: got %0h expected %0h", rdFlit, expQ[0]);
            end
            void'(expQ.pop_front());
            got++;
            if (got == 3) begin
               retryReq = 1'b1;
               retryEseq = 3'd2;
            end
         end
         tick();
         cyc++;
      end
      retryReq = 1'b0;
      vecCount++; if (got != 3) begin failCount++; $display("[TB] FAIL restart_pre_count: got %0d flits expected 3", got); end
      vecCount++; if (retryAck !== 1'b1 || rdValid !== 1'b0 || bufConsumed !== 4'd6) begin
         failCount++; $display("[TB] FAIL restart_ack: got ack %b valid %b cnt %0d expected 1 0 6", retryAck, rdValid, bufConsumed);
      end
      expQ.delete();
      pushReplay(2, 6);
      drainReplay("restart", 30);
      vecCount++; if (wrtPtr !== 3'd0 || wrReady !== 1'b1) begin
         failCount++; $display("[TB] FAIL restart_wr_blocked: got ptr %0d ready %b expected ptr 0 ready 1", wrtPtr, wrReady);
      end
      tick();
      wrEn = 1'b0;
      rdReady = 1'b0;
      vecCount++; if (wrtPtr !== 3'd1 || bufConsumed !== 4'd7) begin
         failCount++; $display("[TB] FAIL restart_wr_after: got ptr %0d cnt %0d expected ptr 1 cnt 7", wrtPtr, bufConsumed);
      end
   endtask

   task automatic test_lrsm_ack();
      applyReset();
      crcErr = 1'b1;
      tick();
      crcErr = 1'b0;
      vecCount++; if (lrsmState !== 3'd1 || sendRetryReq !== 1'b1 || discard !== 1'b1) begin
         failCount++; $display("[TB] FAIL lrsm_req: got st %0d req %b disc %b expected 1 1 1", lrsmState, sendRetryReq, discard);
      end
      tick();
      tick();
      vecCount++; if (lrsmState !== 3'd1) begin failCount++; $display("[TB] FAIL lrsm_req_hold: got %0d expected 1", lrsmState); end
      ctrlSent = 1'b1;
      tick();
      ctrlSent = 1'b0;
      vecCount++; if (lrsmState !== 3'd2 || sendRetryReq !== 1'b0) begin
         failCount++; $display("[TB] FAIL lrsm_wait: got st %0d req %b expected 2 0", lrsmState, sendRetryReq);
      end
      crcErr = 1'b1;
      tick();
      crcErr = 1'b0;
      vecCount++; if (lrsmState !== 3'd2) begin failCount++; $display("[TB] FAIL lrsm_crc_ignored: got %0d expected 2", lrsmState); end
      tick();
      tick();
      tick();
      remoteRetryAck = 1'b1;
      tick();
      remoteRetryAck = 1'b0;
      vecCount++; if (lrsmState !== 3'd0 || discard !== 1'b0) begin
         failCount++; $display("[TB] FAIL lrsm_normal: got st %0d disc %b expected 0 0", lrsmState, discard);
      end
   endtask

`ifdef LLR_TIMEOUT_EN
   task automatic test_escalation();
      logic [2:0] expSt [4] = '{3'd1, 3'd3, 3'd1, 3'd4};
      applyReset();
      crcErr = 1'b1;
      tick();
      crcErr = 1'b0;
      for (int r = 0; r < 4; r++) begin
         ctrlSent = 1'b1;
         tick();
         ctrlSent = 1'b0;
         for (int c = 0; c < 10; c++) tick();
         vecCount++; if (lrsmState !== 3'd2) begin failCount++; $display("[TB] FAIL esc_wait_%0d: got %0d expected 2", r, lrsmState); end
         tick();
         vecCount++; if (lrsmState !== expSt[r]) begin failCount++; $display("[TB] FAIL esc_timeout_%0d: got %0d expected %0d", r, lrsmState, expSt[r]); end
         if (r == 1) begin
            vecCount++; if (phyReinitReq !== 1'b1 || discard !== 1'b1) begin
               failCount++; $display("[TB] FAIL esc_phy_req: got %b disc %b expected 1 1", phyReinitReq, discard);
            end
            tick();
            phyLinkUp = 1'b1;
            tick();
            phyLinkUp = 1'b0;
            vecCount++; if (lrsmState !== 3'd1) begin failCount++; $display("[TB] FAIL esc_linkup: got %0d expected 1", lrsmState); end
         end
      end
      vecCount++; if (linkFailure !== 1'b1 || phyReinitReq !== 1'b0) begin
         failCount++; $display("[TB] FAIL esc_abort: got fail %b phy %b expected 1 0", linkFailure, phyReinitReq);
      end
      remoteRetryAck = 1'b1;
      tick();
      remoteRetryAck = 1'b0;
      vecCount++; if (lrsmState !== 3'd4 || linkFailure !== 1'b1) begin
         failCount++; $display("[TB] FAIL esc_sticky: got st %0d fail %b expected 4 1", lrsmState, linkFailure);
      end
   endtask
`else
   task automatic test_no_timeout();
      int leftWait = 0;
      applyReset();
      crcErr = 1'b1;
      tick();
      crcErr = 1'b0;
      ctrlSent = 1'b1;
      tick();
      ctrlSent = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         tick();
         if (lrsmState !== 3'd2 || phyReinitReq !== 1'b0 || linkFailure !== 1'b0) leftWait++;
      end
      vecCount++; if (leftWait != 0) begin failCount++; $display("[TB] FAIL no_timeout: got %0d cycles outside wait, expected 0", leftWait); end
      remoteRetryAck = 1'b1;
      tick();
      remoteRetryAck = 1'b0;
      vecCount++; if (lrsmState !== 3'd0) begin failCount++; $display("[TB] FAIL no_timeout_ack: got %0d expected 0", lrsmState); end
   endtask
`endif

   initial begin
      reset = 1'b1;
      wrEn = 1'b0; wrFlit = '0; ackValid = 1'b0; ackNum = '0;
      retryReq = 1'b0; retryEseq = '0; rdReady = 1'b0;
      crcErr = 1'b0; ctrlSent = 1'b0; remoteRetryAck = 1'b0; phyLinkUp = 1'b0;
      retryThreshold = 5'd2; reinitThreshold = 5'd2; timeoutMax = 13'd10;
      test_reset();
      test_fill_ack();
      test_retry_replay();
      test_eseq_range();
      test_restart();
      test_lrsm_ack();
`ifdef LLR_TIMEOUT_EN
      test_escalation();
`else
      test_no_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
